// File: rtl/fifo_rd_stream.sv
// Read-side adapter from an async FIFO (1-cycle read latency) to a valid/ready stream.
// Optional accepted-word counter on out_count is enabled by defining FIFO_RD_STREAM_CNT_EN.
module fifo_rd_stream #(
    parameter int unsigned DATASIZE = 8
) (
    input  logic                rclk,
    input  logic                rst,
    input  logic                empty,
    input  logic [DATASIZE-1:0] rdata,
    output logic                rinc,
    output logic                m_valid,
    output logic [DATASIZE-1:0] m_data,
    input  logic                m_ready,
    output logic [1:0]          buf_cnt
`ifdef FIFO_RD_STREAM_CNT_EN
    ,
    output logic [15:0]         out_count
`endif
);

    localparam int unsigned LVLW = 3;

    logic [DATASIZE-1:0] mem [2];
    logic                head;
    logic                tail;
    logic                inflight;
    logic                pop;
    logic [LVLW-1:0]     level;

    assign m_valid = (buf_cnt != 2'd0);
    assign m_data  = mem[head];

    // Credit: words held plus the word on its way must stay within the two entries.
    always_comb begin
        pop   = m_valid & m_ready;
        level = LVLW'(buf_cnt) + LVLW'(inflight) - LVLW'(pop);
        rinc  = ~rst & ~empty & (level < LVLW'(2));
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            inflight <= 1'b0;
            head     <= 1'b0;
            tail     <= 1'b0;
            buf_cnt  <= 2'd0;
        end else begin
            inflight <= rinc;
            buf_cnt  <= 2'(level);
            if (inflight) tail <= ~tail;
            if (pop)      head <= ~head;
        end
    end

    // Storage carries no reset; occupancy alone decides validity.
    always_ff @(posedge rclk) begin
        if (!rst && inflight) mem[tail] <= rdata;
    end

`ifdef FIFO_RD_STREAM_CNT_EN
    always_ff @(posedge rclk) begin
        if (rst)      out_count <= 16'd0;
        else if (pop) out_count <= out_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream with a 1-cycle-latency FIFO model on the read port.
// Counter checks are built only when FIFO_RD_STREAM_CNT_EN is defined.
module tb_fifo_rd_stream;

    logic       rclk;
    logic       rst;
    logic       empty;
    logic [7:0] rdata;
    logic       rinc;
    logic       m_valid;
    logic [7:0] m_data;
    logic       m_ready;
    logic [1:0] buf_cnt;
`ifdef FIFO_RD_STREAM_CNT_EN
    logic [15:0] out_count;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [7:0] fmem [256];
    logic [7:0] wr_ptr = 8'd0;
    logic [7:0] rd_ptr = 8'd0;

    fifo_rd_stream #(.DATASIZE(8)) dut (
        .rclk      (rclk),
        .rst       (rst),
        .empty     (empty),
        .rdata     (rdata),
        .rinc      (rinc),
        .m_valid   (m_valid),
        .m_data    (m_data),
        .m_ready   (m_ready),
        .buf_cnt   (buf_cnt)
`ifdef FIFO_RD_STREAM_CNT_EN
        ,
        .out_count (out_count)
`endif
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    // FIFO read port model: data appears the cycle after rinc.
    assign empty = (wr_ptr == rd_ptr);
    always @(posedge rclk) begin
        if (rinc) begin
            rdata  <= fmem[rd_ptr];
            rd_ptr <= rd_ptr + 8'd1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d);
        fmem[wr_ptr] = d;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    task automatic step();
        @(posedge rclk);
        #2;
    endtask

    initial begin
        int n;
        rst     = 1'b1;
        m_ready = 1'b0;
        rdata   = 8'd0;

        // Reset holds rinc low even with a word waiting.
        push(8'hA5);
        step();
        step();
        check_eq("rst_rinc", 32'(rinc), 32'd0);
        check_eq("rst_m_valid", 32'(m_valid), 32'd0);
        check_eq("rst_buf_cnt", 32'(buf_cnt), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
        check_eq("rst_out_count", 32'(out_count), 32'd0);
`endif

        // Single word then empty: one rinc, word held until accepted.
        rst = 1'b0;
        #1;
        check_eq("single_rinc_first", 32'(rinc), 32'd1);
        n = 1;
        step();
        check_eq("single_rinc_off", 32'(rinc), 32'd0);
        check_eq("single_no_valid_yet", 32'(m_valid), 32'd0);
        step();
        check_eq("single_valid", 32'(m_valid), 32'd1);
        check_eq("single_data", 32'(m_data), 32'hA5);
        check_eq("single_buf_cnt", 32'(buf_cnt), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            if (rinc) n++;
            check_eq("single_hold_valid", 32'(m_valid), 32'd1);
            check_eq("single_hold_data", 32'(m_data), 32'hA5);
        end
        check_eq("single_rinc_pulses", 32'(n), 32'd1);
        m_ready = 1'b1;
        #1;
        step();
        check_eq("single_drained_valid", 32'(m_valid), 32'd0);
        check_eq("single_drained_cnt", 32'(buf_cnt), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
        check_eq("single_out_count", 32'(out_count), 32'd1);
`endif

        // Streaming 16 words at full rate.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 16; i++) push(8'(i + 1));
        #1;
        for (int k = 0; k < 19; k++) begin
            if (k > 0) step();
            check_eq("stream_rinc", 32'(rinc), (k < 16) ? 32'd1 : 32'd0);
            check_eq("stream_valid", 32'(m_valid), (k >= 2 && k < 18) ? 32'd1 : 32'd0);
            if (k >= 2 && k < 18) check_eq("stream_data", 32'(m_data), 32'(k - 1));
        end
        check_eq("stream_buf_cnt", 32'(buf_cnt), 32'd0);
`ifdef FIFO_RD_STREAM_CNT_EN
        check_eq("stream_out_count", 32'(out_count), 32'd16);
`endif

        // Backpressure with 5 queued words, then release.
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) push(8'(i + 1));
        #1;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            if (k > 0) step();
            if (rinc) n++;
        end
        check_eq("bp_rinc_pulses", 32'(n), 32'd2);
        check_eq("bp_buf_cnt", 32'(buf_cnt), 32'd2);
        check_eq("bp_rinc_stalled", 32'(rinc), 32'd0);
        check_eq("bp_head", 32'(m_data), 32'h01);
        m_ready = 1'b1;
        #1;
        check_eq("bp_release_rinc", 32'(rinc), 32'd1);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) step();
            check_eq("bp_valid", 32'(m_valid), 32'd1);
            check_eq("bp_data", 32'(m_data), 32'(k + 1));
            if (k == 1) begin
                check_eq("simul_buf_cnt", 32'(buf_cnt), 32'd1);
                check_eq("simul_rinc", 32'(rinc), 32'd1);
            end
            if (k == 2) check_eq("simul_buf_cnt_after", 32'(buf_cnt), 32'd1);
        end
        step();
        check_eq("bp_done_valid", 32'(m_valid), 32'd0);
        check_eq("bp_done_cnt", 32'(buf_cnt), 32'd0);

        // Reset drains a full buffer.
        m_ready = 1'b0;
        push(8'h11);
        push(8'h22);
        #1;
        step();
        step();
        step();
        check_eq("drain_pre_cnt", 32'(buf_cnt), 32'd2);
        check_eq("drain_pre_data", 32'(m_data), 32'h11);
        rst = 1'b1;
        #1;
        check_eq("drain_rst_rinc", 32'(rinc), 32'd0);
        step();
        rst = 1'b0;
        #1;
        check_eq("drain_buf_cnt", 32'(buf_cnt), 32'd0);
        check_eq("drain_valid", 32'(m_valid), 32'd0);
        check_eq("drain_rinc", 32'(rinc), 32'd0);

`ifdef FIFO_RD_STREAM_CNT_EN
        // Counter wraps after 65536 accepted words.
        begin
            int  pops;
            bit  done;
            pops = 0;
            done = 1'b0;
            m_ready = 1'b1;
            for (int cyc = 0; cyc < 70000 && !done; cyc++) begin
                step();
                if (pops == 65535) check_eq("wrap_max", 32'(out_count), 32'hFFFF);
                if (pops == 65536) begin
                    check_eq("wrap_zero", 32'(out_count), 32'd0);
                    done = 1'b1;
                end
                if (!done) begin
                    if (m_valid) pops++;
                    if (8'(wr_ptr - rd_ptr) < 8'd3) push(8'(cyc));
                end
            end
            check_eq("wrap_timeout", 32'(done), 32'd1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/fifo_rd_stream.md
FIFO_RD_STREAM -- requirements
Module: fifo_rd_stream

Interface
REQ-001 Parameter DATASIZE, default 8, word width; matches the async FIFO read port.
REQ-002 Port rclk  input  1  read-domain clock; all logic on its rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port empty  input  1  FIFO read-side empty flag.
REQ-005 Port rdata  input  DATASIZE  FIFO read data, valid the cycle after a rinc pulse.
REQ-006 Port rinc  output  1  FIFO read increment, one word per high cycle.
REQ-007 Port m_valid  output  1  stream word available.
REQ-008 Port m_data  output  DATASIZE  stream word.
REQ-009 Port m_ready  input  1  downstream accepts.
REQ-010 Port buf_cnt  output  2  skid-buffer occupancy, 0..2.
REQ-011 Port out_count  output  16  accepted-word count; present only under FIFO_RD_STREAM_CNT_EN.

Function
REQ-012 Block SHALL hold a 2-entry in-order skid buffer (head/tail pointers, buf_cnt register) plus a 1-bit inflight register.
REQ-013 pop = m_valid & m_ready; m_valid = (buf_cnt != 0); m_data = head entry, stable while m_valid & !m_ready.
REQ-014 rinc = !rst & !empty & (buf_cnt + inflight - pop < 2), combinational; the path from m_ready to rinc is permitted.
REQ-015 inflight <= rinc each cycle; read latency is fixed at 1 cycle.
REQ-016 When inflight=1, rdata SHALL be written to the tail entry that cycle; the tail pointer wraps 1->0.
REQ-017 On pop, the head pointer advances with wrap 1->0.
REQ-018 buf_cnt <= buf_cnt + inflight - pop; simultaneous write and pop leaves buf_cnt unchanged.
REQ-019 The credit rule SHALL guarantee buf_cnt + inflight <= 2; no word is overwritten or dropped, and order is preserved.
REQ-020 Sustained throughput SHALL be 1 word/cycle when empty=0 and m_ready=1.
REQ-021 First-word latency: empty falls at cycle N; rinc is high at N; m_valid is high at N+2.
REQ-022 If empty=1, rinc=0; a word already in flight is still captured.
REQ-023 If m_ready=0 with buf_cnt=2, rinc=0 until a pop occurs.

Reset
REQ-024 While rst=1: rinc=0, m_valid=0, buf_cnt=0, inflight=0, pointers=0, out_count=0; m_data is don't-care.
REQ-025 Reset asserted mid-operation discards buffered and in-flight words; the integrator SHALL reset the FIFO read side in the same window.
REQ-026 On the first cycle after rst falls, rinc MAY assert if empty=0.

Configuration
REQ-027 Macro FIFO_RD_STREAM_CNT_EN defined: out_count SHALL increment by 1 on each pop, wrap 16'hFFFF->0, and be cleared by rst.
REQ-028 Macro FIFO_RD_STREAM_CNT_EN undefined: the out_count port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Reset drain: buf_cnt=2 and inflight=0, then rst=1 for 1 cycle -> next cycle buf_cnt=0, m_valid=0, rinc=0.
REQ-030 Streaming: FIFO preloaded with 0x01..0x10, m_ready=1 -> rinc high for 16 consecutive cycles, m_data=0x01..0x10 on 16 consecutive cycles starting 2 cycles after the first rinc, out_count=16.
REQ-031 Backpressure: m_ready=0 with 5 words queued -> exactly 2 rinc pulses, buf_cnt=2; m_ready=1 -> 0x01..0x05 delivered in order with no gaps.
REQ-032 Simultaneous write and pop: buf_cnt=1, inflight=1, pop=1 -> buf_cnt stays 1 and rinc=1 that cycle.
REQ-033 Empty edge: single word 0xA5 written, then empty=1 -> one rinc pulse, m_valid=1 with m_data=0xA5 held until m_ready, then m_valid=0.
REQ-034 Counter wrap (macro defined): out_count preset via 65535 pops, one more pop -> out_count=0.
